// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with parity, framing and overrun status.
// Define UART_RX_BREAK_DET_EN to add break detection and a line-high rearm after a break.
module uart_rx (
    input  logic       baud_clk,
    input  logic       reset_n,
    input  logic       rxd_i,
    input  logic [1:0] wls,
    input  logic       parity_en,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic       Rxhr_full,
    output logic [7:0] rx_data_o,
    output logic       rx_done,
    output logic       Rxhr_wr_en,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overrun_err,
    output logic       break_o
);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
    logic [2:0] state;
    logic [3:0] clk_counter;
    logic [2:0] bit_counter;
    logic [7:0] data_reg;
    logic       rxd_m, rxd_s, par_mismatch, start_ok;
    logic       mid, last_bit, exp_parity;
    assign mid        = clk_counter == 4'd15;
    assign last_bit   = bit_counter == {1'b0, wls} + 3'd4;
    assign exp_parity = sticky_parity ? ~eps : (eps ? ^data_reg : ~^data_reg);
`ifdef UART_RX_BREAK_DET_EN
    logic all_zero, line_wait;
    assign start_ok = ~rxd_s & ~line_wait;
    // A break holds the receiver off until the line has returned high.
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            all_zero  <= 1'b1;
            line_wait <= 1'b0;
            break_o   <= 1'b0;
        end else begin
            if (state == IDLE)
                all_zero <= 1'b1;
            else if ((state == DATA || state == PARITY) && mid)
                all_zero <= all_zero & ~rxd_s;
            if (state == STOP && mid) begin
                break_o   <= all_zero & ~rxd_s;
                line_wait <= all_zero & ~rxd_s;
            end else if (rxd_s)
                line_wait <= 1'b0;
        end
    end
`else
    assign start_ok = ~rxd_s;
    assign break_o  = 1'b0;
`endif
    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_m        <= 1'b1;
            rxd_s        <= 1'b1;
            state        <= IDLE;
            clk_counter  <= 4'd0;
            bit_counter  <= 3'd0;
            data_reg     <= 8'd0;
            par_mismatch <= 1'b0;
            rx_data_o    <= 8'd0;
            rx_done      <= 1'b0;
            Rxhr_wr_en   <= 1'b0;
            parity_err   <= 1'b0;
            framing_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            rxd_m      <= rxd_i;
            rxd_s      <= rxd_m;
            rx_done    <= 1'b0;
            Rxhr_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    clk_counter  <= 4'd0;
                    bit_counter  <= 3'd0;
                    data_reg     <= 8'd0;
                    par_mismatch <= 1'b0;
                    if (start_ok) state <= START;
                end
                START: begin
                    if (clk_counter == 4'd7) begin
                        clk_counter <= 4'd0;
                        state       <= rxd_s ? IDLE : DATA;
                    end else clk_counter <= clk_counter + 4'd1;
                end
                DATA: begin
                    if (mid) begin
                        data_reg[bit_counter] <= rxd_s;
                        bit_counter           <= bit_counter + 3'd1;
                        clk_counter           <= 4'd0;
                        if (last_bit) state <= parity_en ? PARITY : STOP;
                    end else clk_counter <= clk_counter + 4'd1;
                end
                PARITY: begin
                    if (mid) begin
                        par_mismatch <= rxd_s != exp_parity;
                        clk_counter  <= 4'd0;
                        state        <= STOP;
                    end else clk_counter <= clk_counter + 4'd1;
                end
                STOP: begin
                    if (mid) begin
                        state       <= IDLE;
                        rx_data_o   <= data_reg;
                        framing_err <= ~rxd_s;
                        parity_err  <= par_mismatch;
                        overrun_err <= Rxhr_full;
                        rx_done     <= 1'b1;
                        Rxhr_wr_en  <= 1'b1;
                    end else clk_counter <= clk_counter + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector bench for uart_rx; break checks run when UART_RX_BREAK_DET_EN is defined.
module tb_uart_rx;
    logic       baud_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd_i = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       parity_en = 1'b0, eps = 1'b0, sticky_parity = 1'b0, Rxhr_full = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_done, Rxhr_wr_en, parity_err, framing_err, overrun_err, break_o;

    uart_rx dut (
        .baud_clk(baud_clk), .reset_n(reset_n), .rxd_i(rxd_i), .wls(wls),
        .parity_en(parity_en), .eps(eps), .sticky_parity(sticky_parity),
        .Rxhr_full(Rxhr_full), .rx_data_o(rx_data_o), .rx_done(rx_done),
        .Rxhr_wr_en(Rxhr_wr_en), .parity_err(parity_err), .framing_err(framing_err),
        .overrun_err(overrun_err), .break_o(break_o)
    );

    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic [1:0] wls;
        logic       pen, eps, stk, full;
        logic [7:0] data;
        logic       par, stop;
        logic [7:0] exp_data;
        logic       exp_pe, exp_fe, exp_oe;
    } vec_t;

    vec_t       vecs[9];
    int         tests = 0, fails = 0;
    int         done_cnt = 0, wr_cnt = 0, d0, w0, lat;
    logic [7:0] cap[$];

    always @(negedge baud_clk) begin
        if (rx_done) begin
            done_cnt++;
            cap.push_back(rx_data_o);
        end
        if (Rxhr_wr_en) wr_cnt++;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic b);
        rxd_i = b;
        repeat (16) @(negedge baud_clk);
    endtask

    task automatic send_frame(input logic [1:0] w, input logic pen, input logic [7:0] d,
                              input logic par, input logic stop, input int gap);
        bit_time(1'b0);
        for (int i = 0; i < int'(w) + 5; i++) bit_time(d[i]);
        if (pen) bit_time(par);
        bit_time(stop);
        rxd_i = 1'b1;
        repeat (16 * gap) @(negedge baud_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //             wls    pen   eps   stk   full  data   par   stop  exp    pe    fe    oe
        vecs[0] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0, 1'b0, 8'h15, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h3F, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge baud_clk);
        check("reset data", rx_data_o, 8'h00);
        check("reset done", {7'd0, rx_done}, 8'd0);
        check("reset wr_en", {7'd0, Rxhr_wr_en}, 8'd0);
        check("reset pe", {7'd0, parity_err}, 8'd0);
        check("reset fe", {7'd0, framing_err}, 8'd0);
        check("reset oe", {7'd0, overrun_err}, 8'd0);
        check("reset break", {7'd0, break_o}, 8'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge baud_clk);

        // 8N1 0x5A with exact completion latency from the start-bit edge
        d0 = done_cnt; w0 = wr_cnt;
        fork
            send_frame(2'b11, 1'b0, 8'h5A, 1'b0, 1'b1, 1);
            begin
                lat = 0;
                while (!rx_done && lat < 400) begin
                    @(negedge baud_clk);
                    lat++;
                end
            end
        join
        check("8n1 latency", 8'(lat), 8'd155);
        check("8n1 data", rx_data_o, 8'h5A);
        check("8n1 done pulses", 8'(done_cnt - d0), 8'd1);
        check("8n1 wr pulses", 8'(wr_cnt - w0), 8'd1);
        check("8n1 errs", {5'd0, parity_err, framing_err, overrun_err}, 8'd0);

        for (int i = 0; i < 9; i++) begin
            wls = vecs[i].wls; parity_en = vecs[i].pen; eps = vecs[i].eps;
            sticky_parity = vecs[i].stk; Rxhr_full = vecs[i].full;
            d0 = done_cnt; w0 = wr_cnt;
            send_frame(vecs[i].wls, vecs[i].pen, vecs[i].data, vecs[i].par, vecs[i].stop, 1);
            check($sformatf("v%0d data", i), rx_data_o, vecs[i].exp_data);
            check($sformatf("v%0d pe", i), {7'd0, parity_err}, {7'd0, vecs[i].exp_pe});
            check($sformatf("v%0d fe", i), {7'd0, framing_err}, {7'd0, vecs[i].exp_fe});
            check($sformatf("v%0d oe", i), {7'd0, overrun_err}, {7'd0, vecs[i].exp_oe});
            check($sformatf("v%0d done", i), 8'(done_cnt - d0), 8'd1);
            check($sformatf("v%0d wr", i), 8'(wr_cnt - w0), 8'd1);
        end
        Rxhr_full = 1'b0; wls = 2'b11; parity_en = 1'b0; eps = 1'b0; sticky_parity = 1'b0;

        // short low glitch in idle is rejected and leaves status alone
        d0 = done_cnt;
        rxd_i = 1'b0;
        repeat (4) @(negedge baud_clk);
        rxd_i = 1'b1;
        repeat (40) @(negedge baud_clk);
        check("glitch done", 8'(done_cnt - d0), 8'd0);
        check("glitch data held", rx_data_o, 8'hC3);
        check("glitch oe held", {7'd0, overrun_err}, 8'd1);

        // reset mid-data aborts the frame
        d0 = done_cnt;
        fork
            send_frame(2'b11, 1'b0, 8'hFC, 1'b0, 1'b1, 1);
            begin
                repeat (40) @(negedge baud_clk);
                reset_n = 1'b0;
                repeat (2) @(negedge baud_clk);
                check("midreset data", rx_data_o, 8'h00);
                check("midreset oe", {7'd0, overrun_err}, 8'd0);
                check("midreset done", {7'd0, rx_done}, 8'd0);
                repeat (10) @(negedge baud_clk);
                reset_n = 1'b1;
            end
        join
        repeat (20) @(negedge baud_clk);
        check("midreset no done", 8'(done_cnt - d0), 8'd0);
        check("midreset data stays", rx_data_o, 8'h00);

        // back-to-back frames with no idle gap
        d0 = done_cnt;
        send_frame(2'b11, 1'b0, 8'h33, 1'b0, 1'b1, 0);
        send_frame(2'b11, 1'b0, 8'hCC, 1'b0, 1'b1, 1);
        check("b2b done", 8'(done_cnt - d0), 8'd2);
        check("b2b first", cap[cap.size() - 2], 8'h33);
        check("b2b second", rx_data_o, 8'hCC);

`ifdef UART_RX_BREAK_DET_EN
        d0 = done_cnt;
        rxd_i = 1'b0;
        repeat (200) @(negedge baud_clk);
        check("break flag", {7'd0, break_o}, 8'd1);
        check("break fe", {7'd0, framing_err}, 8'd1);
        check("break data", rx_data_o, 8'h00);
        check("break done", 8'(done_cnt - d0), 8'd1);
        repeat (150) @(negedge baud_clk);
        check("break held off", 8'(done_cnt - d0), 8'd1);
        rxd_i = 1'b1;
        repeat (20) @(negedge baud_clk);
        send_frame(2'b11, 1'b0, 8'h55, 1'b0, 1'b1, 1);
        check("after break data", rx_data_o, 8'h55);
        check("after break flag", {7'd0, break_o}, 8'd0);
        check("after break done", 8'(done_cnt - d0), 8'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
